// File: rtl/bloons_pkg.sv
// Purpose: shared types and helpers for the round sequencer slice.
// Latency: n/a (types, constants, pure function only).
// Backpressure: n/a.
package bloons_pkg;

   localparam int NUM_BLOONS_DEF = 32;
   localparam int AUTO_DELAY     = 100000000;   // 2 s at 50 MHz

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SPAWN,
      WAIT_CLEAR,
      DONE,
      AUTO_WAIT,
      GAMEOVER
   } round_state_t;

   // Bloons released in a round: base + (round-1)*step, capped at the slot count.
   // Computed at 16 bits so large rounds cannot wrap before the cap applies.
   function automatic logic [15:0] round_target(input logic [5:0] rnd,
                                                input int base_count,
                                                input int step_count,
                                                input int num_bloons);
      logic [15:0] t;
      t = 16'(base_count) + 16'(rnd - 6'd1) * 16'(step_count);
      if (t > 16'(num_bloons)) begin
         t = 16'(num_bloons);
      end
      return t;
   endfunction

endpackage

// File: rtl/round_sequencer_spawn_timer.sv
// Purpose: spawn cadence generator; ticks once every SPAWN_GAP cycles while running.
// Latency: first tick in the first running cycle after clear, then every SPAWN_GAP cycles.
// Backpressure: none; i_run simply freezes the gap counter and index.
// Ports: Clk/reset (sync, active-high), i_clear (restart at idx 0, gap 0),
//        i_run (count), o_tick (release one bloon this cycle), o_idx (bloons released so far).
module spawn_timer #(
   parameter int SPAWN_GAP = 25000000,
   parameter int IDX_W     = 6
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_run,
   output logic             o_tick,
   output logic [IDX_W-1:0] o_idx
);

   localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

   logic [GAP_W-1:0] r_gap;
   logic [IDX_W-1:0] r_idx;

   assign o_tick = i_run && (r_gap == '0);
   assign o_idx  = r_idx;

   always_ff @(posedge Clk) begin
      if (reset || i_clear) begin
         r_gap <= '0;
         r_idx <= '0;
      end else if (i_run) begin
         if (o_tick) begin
            r_idx <= r_idx + IDX_W'(1);
            r_gap <= GAP_W'(SPAWN_GAP - 1);
         end else begin
            r_gap <= r_gap - GAP_W'(1);
         end
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Purpose: sequences a wave of bloons, tracks pops/escapes, advances rounds, halts on zero lives.
// Latency: ARM one cycle after a start_round edge; bloon k released k*SPAWN_GAP cycles after ARM+1.
// Backpressure: none; start_round edges outside IDLE (or AUTO_WAIT) are dropped.
// Ports: Clk, reset (sync, active-high), start_round (level, rising edge requests a round),
//        bloon_alive/lost_life (per-slot status), lives; bloon_reset (1-cycle pulse),
//        spawn_en (sticky per-slot release), bloonpause/round_active (ARM..WAIT_CLEAR),
//        round_num (1-based), round_done (1-cycle pulse), game_over (sticky).
// Optional: ROUND_AUTOSTART_EN adds AUTO_WAIT, re-arming AUTO_DELAY cycles after DONE.
module round_sequencer
   import bloons_pkg::*;
#(
   parameter int NUM_BLOONS = NUM_BLOONS_DEF,
   parameter int SPAWN_GAP  = 25000000,
   parameter int BASE_COUNT = 4,
   parameter int STEP_COUNT = 2,
   parameter int MAX_ROUND  = 63
) (
   input  logic                  Clk,
   input  logic                  reset,
   input  logic                  start_round,
   input  logic [NUM_BLOONS-1:0] bloon_alive,
   input  logic [NUM_BLOONS-1:0] lost_life,
   input  logic [7:0]            lives,
   output logic                  bloon_reset,
   output logic [NUM_BLOONS-1:0] spawn_en,
   output logic                  bloonpause,
   output logic [5:0]            round_num,
   output logic                  round_active,
   output logic                  round_done,
   output logic                  game_over
);

   localparam int IDX_W = $clog2(NUM_BLOONS + 1);

   round_state_t            r_state;
   round_state_t            w_next;
   logic                    r_start_q;
   logic [NUM_BLOONS-1:0]   r_spawn_en;
   logic [NUM_BLOONS-1:0]   r_finished;
   logic [5:0]              r_round_num;

   logic                    w_req;
   logic                    w_lives_zero;
   logic [15:0]             w_target;
   logic [NUM_BLOONS-1:0]   w_mask;
   logic [NUM_BLOONS-1:0]   w_spawn_now;
   logic [NUM_BLOONS-1:0]   w_fin_set;
   logic                    w_tick;
   logic [IDX_W-1:0]        w_idx;
   logic                    w_timer_run;

`ifdef ROUND_AUTOSTART_EN
   localparam int AUTO_W = $clog2(AUTO_DELAY);
   logic [AUTO_W-1:0] r_auto_cnt;
`endif

   assign w_req        = start_round & ~r_start_q;
   assign w_lives_zero = (lives == 8'd0);
   assign w_target     = round_target(r_round_num, BASE_COUNT, STEP_COUNT, NUM_BLOONS);
   assign w_timer_run  = (r_state == SPAWN) && (16'(w_idx) < w_target);
   assign round_num    = r_round_num;

   spawn_timer #(
      .SPAWN_GAP (SPAWN_GAP),
      .IDX_W     (IDX_W)
   ) u_spawn_timer (
      .Clk     (Clk),
      .reset   (reset),
      .i_clear (r_state == ARM),
      .i_run   (w_timer_run),
      .o_tick  (w_tick),
      .o_idx   (w_idx)
   );

   // r_spawn_en holds last cycle's spawn_en, so it doubles as the settling guard
   // for finished tracking: a slot only counts once it has been enabled a full cycle.
   always_comb begin
      w_mask      = '0;
      w_spawn_now = '0;
      for (int i = 0; i < NUM_BLOONS; i++) begin
         w_mask[i]      = (16'(i) < w_target);
         w_spawn_now[i] = w_tick && (w_idx == IDX_W'(i));
      end
      w_fin_set = r_spawn_en & (~bloon_alive | lost_life);
   end

   // State register
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:       if (w_req && !game_over) w_next = ARM;
         ARM:        w_next = SPAWN;
         SPAWN:      if (16'(w_idx) >= w_target) w_next = WAIT_CLEAR;
         WAIT_CLEAR: if ((r_finished & w_mask) == w_mask) w_next = DONE;
`ifdef ROUND_AUTOSTART_EN
         DONE:       w_next = AUTO_WAIT;
         AUTO_WAIT:  if (w_req || (r_auto_cnt == AUTO_W'(AUTO_DELAY - 1))) w_next = ARM;
`else
         DONE:       w_next = IDLE;
`endif
         GAMEOVER:   w_next = GAMEOVER;
         default:    w_next = IDLE;
      endcase
      // Losing the last life overrides every transition, including DONE.
      if ((r_state != IDLE) && w_lives_zero) begin
         w_next = GAMEOVER;
      end
   end

   // Output logic
   always_comb begin
      bloon_reset  = (r_state == ARM);
      bloonpause   = (r_state == ARM) || (r_state == SPAWN) || (r_state == WAIT_CLEAR);
      round_active = bloonpause;
      // Include this cycle's release so a slot is enabled in the same cycle it spawns.
      spawn_en     = ((r_state == SPAWN) || (r_state == WAIT_CLEAR)) ?
                     (r_spawn_en | w_spawn_now) : '0;
      round_done   = (r_state == DONE) && !w_lives_zero;
      game_over    = (r_state == GAMEOVER);
   end

   // Round datapath: spawn enables, finished mask, round number
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_start_q   <= 1'b0;
         r_spawn_en  <= '0;
         r_finished  <= '0;
         r_round_num <= 6'd1;
      end else begin
         r_start_q <= start_round;
         if (w_next == GAMEOVER) begin
            r_spawn_en <= '0;
            r_finished <= '0;
         end else begin
            case (r_state)
               ARM: begin
                  r_spawn_en <= '0;
                  r_finished <= '0;
               end
               SPAWN, WAIT_CLEAR: begin
                  r_spawn_en <= r_spawn_en | w_spawn_now;
                  r_finished <= r_finished | w_fin_set;
               end
               DONE: begin
                  r_spawn_en <= '0;
                  if (r_round_num < 6'(MAX_ROUND)) begin
                     r_round_num <= r_round_num + 6'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef ROUND_AUTOSTART_EN
   always_ff @(posedge Clk) begin
      if (reset || (r_state != AUTO_WAIT)) begin
         r_auto_cnt <= '0;
      end else begin
         r_auto_cnt <= r_auto_cnt + AUTO_W'(1);
      end
   end
`endif

endmodule
